// File: rtl/sig_lut_arbiter_pkg.sv
// Shared constants and helpers for the sigmoid LUT arbiter slice.
package sig_lut_arbiter_pkg;

    // Width of one sigmoid table entry; 1.0 is encoded as 12'h100.
    localparam int unsigned ROM_BITWIDTH = 12;

    // Round-robin successor of idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sig_res_fifo.sv
// Small synchronous result FIFO with first-word fall-through head.
module sig_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head is forced to zero while empty so stale entries never show after reset.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sig_lut_arbiter.sv
// Round-robin sharing of one sign-folded sigmoid ROM among NUM_REQ requesters,
// with tag tracking through the ROM latency and a credit-guarded result FIFO.
module sig_lut_arbiter
    import sig_lut_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IN_W      = 10,
    parameter int unsigned OUT_W     = ROM_BITWIDTH,
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IN_W-1:0]    req_x,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IN_W-1:0]            rom_addr,
    output logic                       rom_sign,
    input  logic [OUT_W-1:0]           rom_data,
    output logic                       res_valid,
    output logic [OUT_W-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    input  logic                       res_ready,
    output logic                       busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned FW    = OUT_W + ID_W;
    localparam logic [IN_W-1:0] X_MIN = {1'b1, {(IN_W-1){1'b0}}};

    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_credit;
    logic [ROM_LAT-1:0] r_tag_v;
    logic [ID_W-1:0]  r_tag_id [ROM_LAT];

    logic             w_found;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_cand;
    logic             w_issue;
    logic             w_pop;
    logic [IN_W-1:0]  w_x;
    logic [IN_W-1:0]  w_addr;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [$clog2(RES_DEPTH+1)-1:0] w_fifo_count;
    logic [FW-1:0]    w_fifo_din;
    logic [FW-1:0]    w_fifo_dout;
    logic             w_push;

    // Rotating-priority search: first valid requester at or after r_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_cand   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_cand = ID_W'((32'(r_ptr) + off) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_gnt_id = w_cand;
            end
        end
    end

    // Held low during reset so no handshake can complete while the block is cleared.
    assign w_issue   = rst_n & w_found & (r_credit != '0);
    assign req_ready = w_issue ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign w_pop     = res_valid & res_ready;

    // Most-negative input is nudged up by one so the ROM's internal negation stays in range.
    assign w_x    = req_x[32'(w_gnt_id)*IN_W +: IN_W];
    assign w_addr = (w_x == X_MIN) ? (X_MIN + IN_W'(1)) : w_x;

    // Pointer advances past the winner; untouched when nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= ID_W'(rr_next(32'(w_gnt_id), NUM_REQ));
        end
    end

    // Credit counts free result slots not yet claimed by in-flight or queued results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= CNT_W'(RES_DEPTH);
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credit <= r_credit - CNT_W'(1);
                2'b01:   r_credit <= r_credit + CNT_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // ROM address/sign register, loaded only on an issued request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rom_sign <= 1'b0;
        end else if (w_issue) begin
            rom_addr <= w_addr;
            rom_sign <= w_x[IN_W-1];
        end
    end

    // Tag shift register mirrors the ROM pipeline so each result keeps its requester id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gnt_id;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_push     = r_tag_v[ROM_LAT-1] & (~w_fifo_full | w_pop);
    assign w_fifo_din = {rom_data, r_tag_id[ROM_LAT-1]};

    sig_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FW)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign res_valid = ~w_fifo_empty;
    assign res_data  = w_fifo_dout[FW-1:ID_W];
    assign res_id    = w_fifo_dout[ID_W-1:0];
    assign busy      = (|r_tag_v) | (w_fifo_count != '0);

endmodule
